// File: rtl/muldiv_if.sv
// muldiv_if -- request/result bundle between the pipeline and muldiv_unit.
//
// Handshake: Start_ID is a request level, sampled on the rising clock edge.
// It is taken only when the unit is idle (Busy=0) and Cancel=0. While Busy=1,
// a Start_ID or MfReq_ID request raises MdStall. The pipeline must then hold
// the request, unchanged, until MdStall drops. Done is a one-cycle pulse. In
// that cycle HI/LO already hold the new result.
//
// Signals:
//   Start_ID   launch request                 Op_ID     00 MULT 01 MULTU 10 DIV 11 DIVU
//   SrcA_ID    multiplicand / dividend        SrcB_ID   multiplier / divisor
//   MfReq_ID   MFHI/MFLO in execute           MfHi_ID   1 = HI, 0 = LO
//   Cancel     pipeline flush                 Busy      iterative op in progress
//   MdStall    stall request                  MfDat     selected HI or LO
//   Done       result-written pulse           state_dbg FSM state for observation
interface muldiv_if;
  logic        Start_ID;
  logic [1:0]  Op_ID;
  logic [31:0] SrcA_ID;
  logic [31:0] SrcB_ID;
  logic        MfReq_ID;
  logic        MfHi_ID;
  logic        Cancel;
  logic        Busy;
  logic        MdStall;
  logic [31:0] MfDat;
  logic        Done;
  logic [1:0]  state_dbg;

  modport master (
    output Start_ID, Op_ID, SrcA_ID, SrcB_ID, MfReq_ID, MfHi_ID, Cancel,
    input  Busy, MdStall, MfDat, Done, state_dbg
  );

  modport slave (
    input  Start_ID, Op_ID, SrcA_ID, SrcB_ID, MfReq_ID, MfHi_ID, Cancel,
    output Busy, MdStall, MfDat, Done, state_dbg
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32x32 multiply / 32/32 divide with HI/LO registers.
//
// The unit computes one bit per cycle for 32 cycles on operand magnitudes.
// One more FIX cycle then applies the sign correction and writes HI/LO.
// Timing: accept at edge 0. Busy is high for 33 cycles. In the next cycle
// Done pulses and MfDat already shows the new HI/LO.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   md     muldiv_if.slave (request, operands, flush, stall, result readout)
module muldiv_unit (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  md
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // Multiply: {partial high, multiplier shifting out low}.
  // Divide: {remainder, dividend shifting into quotient}.
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;      // |multiplicand| or |divisor|
  logic [31:0] raw_a_q, raw_a_d;    // original dividend, for divide-by-zero HI
  logic        neg_res_q, neg_res_d; // negate product / quotient
  logic        neg_rem_q, neg_rem_d; // negate remainder
  logic        div0_q, div0_d;
  logic        is_div_q, is_div_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        accept;
  logic        op_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_hi, fix_lo;

  assign accept    = (state_q == S_IDLE) && md.Start_ID && !md.Cancel;
  assign op_signed = !md.Op_ID[0];
  assign abs_a     = (op_signed && md.SrcA_ID[31]) ? (~md.SrcA_ID + 32'd1) : md.SrcA_ID;
  assign abs_b     = (op_signed && md.SrcB_ID[31]) ? (~md.SrcB_ID + 32'd1) : md.SrcB_ID;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      raw_a_q   <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      raw_a_q   <= raw_a_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = md.Op_ID[1] ? S_DIV : S_MUL;
      S_MUL,
      S_DIV: begin
        if (md.Cancel)              state_d = S_IDLE;
        else if (cnt_q == 6'd31)    state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- sign fix-up of the finished magnitudes ----------------
  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    if (!is_div_q) begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end else if (div0_q) begin
      // Divide by zero is architecturally defined and gets no sign correction.
      fix_hi = raw_a_q;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end
  end

  // ---------------- datapath / output logic ----------------
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    raw_a_d   = raw_a_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    rem_sh   = {acc_q[63:32], acc_q[31]};
    rem_diff = rem_sh - {1'b0, opnd_q};

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d     = 6'd0;
          is_div_d  = md.Op_ID[1];
          raw_a_d   = md.SrcA_ID;
          div0_d    = md.Op_ID[1] && (md.SrcB_ID == 32'd0);
          neg_res_d = op_signed && (md.SrcA_ID[31] ^ md.SrcB_ID[31]);
          neg_rem_d = op_signed && md.SrcA_ID[31];
          if (md.Op_ID[1]) begin
            acc_d  = {32'd0, abs_a};
            opnd_d = abs_b;
          end else begin
            acc_d  = {32'd0, abs_b};
            opnd_d = abs_a;
          end
        end
      end
      S_MUL: begin
        // Add the multiplicand when the current multiplier bit is set.
        // The carry shifts back into the high half.
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 6'd1;
      end
      S_DIV: begin
        // Restoring step. The remainder is 33 bits wide before the compare,
        // so divisors with bit 31 set are handled correctly.
        if (rem_sh >= {1'b0, opnd_q}) acc_d = {rem_diff[31:0], acc_q[30:0], 1'b1};
        else                          acc_d = {rem_sh[31:0],   acc_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
      end
      S_FIX: begin
        if (!md.Cancel) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign md.Busy      = (state_q != S_IDLE);
  assign md.MdStall   = md.Busy && (md.Start_ID || md.MfReq_ID);
  assign md.MfDat     = md.MfHi_ID ? hi_q : lo_q;
  assign md.Done      = done_q;
  assign md.state_dbg = state_q;

endmodule
